xgmii_ipg_monitor: RTL and testbench

Receive-side inter-packet-gap monitor for the 64-bit XGMII interface. It is the far end of the gap the 10G MAC transmitter produces under `ifg_delay`, DIC and `tx_pause`. It taps `xgmii_rxd`/`xgmii_rxc` in parallel with the MAC receive path and measures every terminate-to-start gap in bytes. Each measurement is buffered in a small FIFO and presented on an AXI-Stream-style output, alongside violation and overflow flags for IPG characterisation.

---
 rtl/xgmii_ipg_monitor.sv | 253 +++++++++++++++++++++++++
 tb/tb_xgmii_ipg_monitor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_ipg_monitor.sv
// ============================================================================
// Module   : xgmii_ipg_monitor
// Purpose  : Receive-side XGMII inter-packet-gap monitor with result FIFO.
//            Optional min/max gap statistics under IPG_MON_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module xgmii_ipg_monitor #(
    parameter int DATA_WIDTH  = 64,
    parameter int CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter int COUNT_WIDTH = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  xgmii_rxd,
    input  logic [CTRL_WIDTH-1:0]  xgmii_rxc,
    input  logic [7:0]             min_gap,
    output logic [COUNT_WIDTH-1:0] m_axis_gap_tdata,
    output logic                   m_axis_gap_tvalid,
    input  logic                   m_axis_gap_tready,
    output logic                   gap_violation,
    output logic                   overflow,
    output logic [31:0]            frame_count,
    input  logic                   stats_clear,
    output logic [COUNT_WIDTH-1:0] gap_min,
    output logic [COUNT_WIDTH-1:0] gap_max
);

    localparam int c_acc_w = COUNT_WIDTH + 1;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);

    localparam logic [c_acc_w-1:0] c_acc_max   = {1'b0, {COUNT_WIDTH{1'b1}}};
    localparam logic [c_acc_w-1:0] c_acc_four  = c_acc_w'(4);
    localparam logic [c_acc_w-1:0] c_acc_eight = c_acc_w'(8);
    localparam logic [c_ptr_w:0]   c_ptr_one   = (c_ptr_w + 1)'(1);

    localparam logic [1:0] c_st_sync     = 2'd0;
    localparam logic [1:0] c_st_in_frame = 2'd1;
    localparam logic [1:0] c_st_in_gap   = 2'd2;

    if (DATA_WIDTH != 64) begin : g_bad_data_width
        $error("xgmii_ipg_monitor: DATA_WIDTH must be 64");
    end
    if (CTRL_WIDTH != DATA_WIDTH / 8) begin : g_bad_ctrl_width
        $error("xgmii_ipg_monitor: CTRL_WIDTH must be DATA_WIDTH/8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("xgmii_ipg_monitor: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    // ------------------------------------------------------------------
    // Lane decode
    // ------------------------------------------------------------------
    logic [7:0] w_is_term;
    logic [7:0] w_is_err;
    logic       w_start0;
    logic       w_start4;
    logic       w_term_any;
    logic       w_err_any;
    logic [2:0] w_term_lane;

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign w_is_term[gi] = xgmii_rxc[gi] && (xgmii_rxd[8*gi +: 8] == 8'hFD);
        assign w_is_err[gi]  = xgmii_rxc[gi] && (xgmii_rxd[8*gi +: 8] == 8'hFE);
    end

    assign w_start0   = xgmii_rxc[0] && (xgmii_rxd[7:0]   == 8'hFB);
    assign w_start4   = xgmii_rxc[4] && (xgmii_rxd[39:32] == 8'hFB);
    assign w_term_any = |w_is_term;
    assign w_err_any  = |w_is_err;

    // The first terminate in the word closes the frame.
    always_comb begin
        w_term_lane = '0;
        for (int i = 7; i >= 0; i--) begin
            if (w_is_term[i]) begin
                w_term_lane = 3'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Gap state machine (first register stage)
    // ------------------------------------------------------------------
    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [c_acc_w-1:0]     r_acc;
    logic [c_acc_w-1:0]     w_acc_next;
    logic                   w_rep_valid;
    logic [c_acc_w-1:0]     w_rep_raw;
    logic [COUNT_WIDTH-1:0] w_rep_data;
    logic                   w_start_acc;
    logic                   r_rep_valid;
    logic [COUNT_WIDTH-1:0] r_rep_data;
    logic [31:0]            r_frame_count;

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_rep_valid  = 1'b0;
        w_rep_raw    = '0;
        w_start_acc  = 1'b0;
        case (r_state)
            c_st_sync: begin
                if (w_start0 || w_start4) begin
                    w_state_next = c_st_in_frame;
                    w_start_acc  = 1'b1;
                end
            end
            c_st_in_frame: begin
                if (w_err_any) begin
                    w_state_next = c_st_sync;
                end else if (w_term_any) begin
                    w_acc_next = c_acc_w'(4'd8 - {1'b0, w_term_lane});
                    if (w_start4 && !w_term_lane[2]) begin
                        w_rep_valid = 1'b1;
                        w_rep_raw   = c_acc_w'(4'd4 - {2'b00, w_term_lane[1:0]});
                        w_start_acc = 1'b1;
                    end else begin
                        w_state_next = c_st_in_gap;
                    end
                end
            end
            c_st_in_gap: begin
                if (w_start0) begin
                    w_rep_valid  = 1'b1;
                    w_rep_raw    = r_acc;
                    w_start_acc  = 1'b1;
                    w_state_next = c_st_in_frame;
                end else if (w_start4) begin
                    w_rep_valid  = 1'b1;
                    w_rep_raw    = r_acc + c_acc_four;
                    w_start_acc  = 1'b1;
                    w_state_next = c_st_in_frame;
                end else if (r_acc < c_acc_max) begin
                    w_acc_next = r_acc + c_acc_eight;
                end
            end
            default: begin
                w_state_next = c_st_sync;
            end
        endcase
    end

    assign w_rep_data = (w_rep_raw > c_acc_max) ? c_acc_max[COUNT_WIDTH-1:0]
                                                : w_rep_raw[COUNT_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_sync;
            r_acc         <= '0;
            r_rep_valid   <= 1'b0;
            r_rep_data    <= '0;
            r_frame_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_rep_valid <= w_rep_valid;
            r_rep_data  <= w_rep_data;
            if (w_start_acc) begin
                r_frame_count <= r_frame_count + 32'd1;
            end
        end
    end

    assign frame_count = r_frame_count;

    // ------------------------------------------------------------------
    // Result FIFO (first-word-fall-through) and report flags
    // ------------------------------------------------------------------
    logic [COUNT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w:0]       r_wr_ptr;
    logic [c_ptr_w:0]       r_rd_ptr;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   r_gap_violation;
    logic                   r_overflow;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign w_pop   = !w_empty && m_axis_gap_tready;
    // A pop frees the full slot in the same edge, so the push still fits.
    assign w_push  = r_rep_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_gap_violation <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_gap_violation <= r_rep_valid &&
                               ({8'd0, r_rep_data} < {{COUNT_WIDTH{1'b0}}, min_gap});
            r_overflow      <= r_rep_valid && w_full && !w_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ptr_w-1:0]] <= r_rep_data;
        end
    end

    assign m_axis_gap_tvalid = !w_empty;
    assign m_axis_gap_tdata  = w_empty ? '0 : r_mem[r_rd_ptr[c_ptr_w-1:0]];
    assign gap_violation     = r_gap_violation;
    assign overflow          = r_overflow;

    // ------------------------------------------------------------------
    // Optional gap statistics
    // ------------------------------------------------------------------
`ifdef IPG_MON_STATS_EN
    logic [COUNT_WIDTH-1:0] r_gap_min;
    logic [COUNT_WIDTH-1:0] r_gap_max;

    // Dropped reports still count: statistics sample before the FIFO.
    always_ff @(posedge clk) begin
        if (rst || stats_clear) begin
            r_gap_min <= '1;
            r_gap_max <= '0;
        end else if (r_rep_valid) begin
            if (r_rep_data < r_gap_min) begin
                r_gap_min <= r_rep_data;
            end
            if (r_rep_data > r_gap_max) begin
                r_gap_max <= r_rep_data;
            end
        end
    end

    assign gap_min = r_gap_min;
    assign gap_max = r_gap_max;
`else
    logic w_unused_stats_clear;
    assign w_unused_stats_clear = stats_clear;
    assign gap_min = '0;
    assign gap_max = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xgmii_ipg_monitor.sv
// ============================================================================
// Module   : tb_xgmii_ipg_monitor
// Purpose  : Directed self-checking bench for xgmii_ipg_monitor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_xgmii_ipg_monitor;

`ifdef IPG_MON_STATS_EN
    localparam logic [31:0] c_min_rst = 32'h0000_FFFF;
    localparam logic [31:0] c_max_rst = 32'd0;
    localparam logic [31:0] c_min_12  = 32'd12;
    localparam logic [31:0] c_max_12  = 32'd12;
    localparam logic [31:0] c_min_fin = 32'd9;
    localparam logic [31:0] c_max_fin = 32'd20;
`else
    localparam logic [31:0] c_min_rst = 32'd0;
    localparam logic [31:0] c_max_rst = 32'd0;
    localparam logic [31:0] c_min_12  = 32'd0;
    localparam logic [31:0] c_max_12  = 32'd0;
    localparam logic [31:0] c_min_fin = 32'd0;
    localparam logic [31:0] c_max_fin = 32'd0;
`endif

    localparam logic [71:0] c_idle = {8'hFF, {8{8'h07}}};

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic [7:0]  min_gap;
    logic        tready;
    logic        sat_tready;
    logic        stats_clear;

    logic [15:0] tdata;
    logic        tvalid;
    logic        gap_violation;
    logic        overflow;
    logic [31:0] frame_count;
    logic [15:0] gap_min;
    logic [15:0] gap_max;

    logic [7:0]  sat_tdata;
    logic        sat_tvalid;
    logic        sat_violation;
    logic        sat_overflow;
    logic [31:0] sat_frame_count;
    logic [7:0]  sat_gap_min;
    logic [7:0]  sat_gap_max;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xgmii_ipg_monitor u_dut (
        .clk               (clk),
        .rst               (rst),
        .xgmii_rxd         (xgmii_rxd),
        .xgmii_rxc         (xgmii_rxc),
        .min_gap           (min_gap),
        .m_axis_gap_tdata  (tdata),
        .m_axis_gap_tvalid (tvalid),
        .m_axis_gap_tready (tready),
        .gap_violation     (gap_violation),
        .overflow          (overflow),
        .frame_count       (frame_count),
        .stats_clear       (stats_clear),
        .gap_min           (gap_min),
        .gap_max           (gap_max)
    );

    xgmii_ipg_monitor #(.COUNT_WIDTH(8)) u_dut_sat (
        .clk               (clk),
        .rst               (rst),
        .xgmii_rxd         (xgmii_rxd),
        .xgmii_rxc         (xgmii_rxc),
        .min_gap           (min_gap),
        .m_axis_gap_tdata  (sat_tdata),
        .m_axis_gap_tvalid (sat_tvalid),
        .m_axis_gap_tready (sat_tready),
        .gap_violation     (sat_violation),
        .overflow          (sat_overflow),
        .frame_count       (sat_frame_count),
        .stats_clear       (stats_clear),
        .gap_min           (sat_gap_min),
        .gap_max           (sat_gap_max)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Builds {rxc, rxd}; term/start < 0 means absent, start is lane 0 or 4.
    function automatic logic [71:0] mk(input int term, input int start);
        logic [63:0] d;
        logic [7:0]  c;
        for (int i = 0; i < 8; i++) begin
            if (term >= 0 && i == term) begin
                d[8*i +: 8] = 8'hFD; c[i] = 1'b1;
            end else if (term >= 0 && i > term && (start != 4 || i < 4)) begin
                d[8*i +: 8] = 8'h07; c[i] = 1'b1;
            end else if (start == 4 && i == 4) begin
                d[8*i +: 8] = 8'hFB; c[i] = 1'b1;
            end else if (start == 4 && i < 4 && term < 0) begin
                d[8*i +: 8] = 8'h07; c[i] = 1'b1;
            end else if (start == 0 && i == 0) begin
                d[8*i +: 8] = 8'hFB; c[i] = 1'b1;
            end else begin
                d[8*i +: 8] = 8'h55; c[i] = 1'b0;
            end
        end
        return {c, d};
    endfunction

    task automatic drive(input logic [71:0] w);
        @(negedge clk);
        {xgmii_rxc, xgmii_rxd} = w;
    endtask

    task automatic send_gap(input int term, input int n_idle, input int start);
        drive(mk(term, -1));
        for (int i = 0; i < n_idle; i++) drive(c_idle);
        drive(mk(-1, start));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] w;
        rst         = 1'b1;
        {xgmii_rxc, xgmii_rxd} = c_idle;
        min_gap     = 8'd12;
        tready      = 1'b1;
        sat_tready  = 1'b1;
        stats_clear = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tdata", 32'(tdata), 32'd0);
        check("rst_viol", 32'(gap_violation), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_fc", frame_count, 32'd0);
        check("rst_min", 32'(gap_min), c_min_rst);
        check("rst_max", 32'(gap_max), c_max_rst);
        rst = 1'b0;

        // First start from SYNC: counted, never reported
        drive(mk(-1, 0));
        drive(c_idle); check("sync_fc", frame_count, 32'd1);
        drive(c_idle); check("sync_noreport", 32'(tvalid), 32'd0);

        // Term lane 3, one idle word, start lane 0 -> 13
        send_gap(3, 1, 0);
        drive(c_idle);
        check("a_fc", frame_count, 32'd2);
        check("a_tvalid_n1", 32'(tvalid), 32'd0);
        drive(c_idle);
        check("a_tvalid", 32'(tvalid), 32'd1);
        check("a_tdata", 32'(tdata), 32'd13);
        check("a_viol", 32'(gap_violation), 32'd0);
        drive(c_idle);
        check("a_popped", 32'(tvalid), 32'd0);

        // Term lane 1 and start lane 4 in one word -> 3, violation
        drive(mk(1, 4));
        drive(c_idle);
        drive(c_idle);
        check("b_tdata", 32'(tdata), 32'd3);
        check("b_viol", 32'(gap_violation), 32'd1);
        drive(c_idle);
        check("b_viol_pulse", 32'(gap_violation), 32'd0);

        // Five gaps into a depth-4 FIFO with the consumer stalled
        tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_gap(4 - k, 1, 0);
            drive(c_idle);
            drive(c_idle);
            check($sformatf("ovf_gap%0d", 12 + k), 32'(overflow), (k == 4) ? 32'd1 : 32'd0);
            if (k == 0) check("ovf_eq_min_noviol", 32'(gap_violation), 32'd0);
        end
        drive(c_idle);
        check("ovf_pulse", 32'(overflow), 32'd0);
        check("hold_tvalid", 32'(tvalid), 32'd1);
        check("hold_tdata", 32'(tdata), 32'd12);
        tready = 1'b1;
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("drain_%0d", j), 32'(tdata), 32'(12 + j));
        end
        @(negedge clk);
        check("drain_empty", 32'(tvalid), 32'd0);

        // 100 idle words: 805 bytes, 255 when COUNT_WIDTH=8
        send_gap(3, 100, 0);
        drive(c_idle);
        drive(c_idle);
        check("long_tdata", 32'(tdata), 32'd805);
        check("sat_tvalid", 32'(sat_tvalid), 32'd1);
        check("sat_tdata", 32'(sat_tdata), 32'd255);

        // Reset in the middle of a gap
        drive(mk(3, -1));
        repeat (3) drive(c_idle);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("mid_rst_fc", frame_count, 32'd0);
        check("mid_rst_tvalid", 32'(tvalid), 32'd0);
        check("mid_rst_min", 32'(gap_min), c_min_rst);
        drive(mk(-1, 0));
        drive(c_idle); check("post_rst_fc", frame_count, 32'd1);
        drive(c_idle); check("post_rst_noreport", 32'(tvalid), 32'd0);
        send_gap(2, 0, 4);
        drive(c_idle);
        drive(c_idle);
        check("post_rst_tdata", 32'(tdata), 32'd10);
        check("post_rst_viol", 32'(gap_violation), 32'd1);
        check("post_rst_fc2", frame_count, 32'd2);

        // Statistics: clear, then gaps 12, 20, 9
        @(negedge clk); stats_clear = 1'b1;
        @(negedge clk); stats_clear = 1'b0;
        check("clr_min", 32'(gap_min), c_min_rst);
        check("clr_max", 32'(gap_max), c_max_rst);
        send_gap(4, 1, 0); drive(c_idle); drive(c_idle);
        check("st12_min", 32'(gap_min), c_min_12);
        check("st12_max", 32'(gap_max), c_max_12);
        send_gap(4, 2, 0); drive(c_idle); drive(c_idle);
        check("st20_tdata", 32'(tdata), 32'd20);
        send_gap(7, 1, 0); drive(c_idle); drive(c_idle);
        check("st9_tdata", 32'(tdata), 32'd9);
        check("st_min", 32'(gap_min), c_min_fin);
        check("st_max", 32'(gap_max), c_max_fin);

        // Clear coinciding with a report: clear wins
        send_gap(4, 0, 0);
        drive(c_idle); stats_clear = 1'b1;
        drive(c_idle); stats_clear = 1'b0;
        check("clrwin_tdata", 32'(tdata), 32'd4);
        check("clrwin_min", 32'(gap_min), c_min_rst);
        check("clrwin_max", 32'(gap_max), c_max_rst);

        w = c_idle;
        drive(w);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
